// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32_pkg
// Description : Shared types and constants for the memory arbiter slice.
//               Memory access size codes, the unsigned-load bit index and
//               the arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32_pkg;

   // ls_size[1:0] access size codes (11 is invalid)
   localparam logic [1:0] MEM_SIZE_B = 2'b00;
   localparam logic [1:0] MEM_SIZE_H = 2'b01;
   localparam logic [1:0] MEM_SIZE_W = 2'b10;

   // ls_size bit that selects zero-extension on loads
   localparam int unsigned MEM_UNSIGNED_BIT = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rv32_mod_lsu_lane.sv
`default_nettype none
// ============================================================================
// Module      : rv32_mod_lsu_lane
// Description : Combinational byte-lane logic for the load/store path.
//               Store side: byte enables, lane replication of store data
//               and the alignment / size check.
//               Load side: extraction of the addressed byte/half from the
//               bus word followed by sign or zero extension.
// Ports       : st_size_i  [1:0]  store-side size code
//               st_off_i   [1:0]  byte offset within word
//               st_wdata_i [31:0] low-aligned store data
//               be_o       [3:0]  byte enables
//               wdata_o    [31:0] lane-replicated store data
//               misalign_o        misaligned or invalid size
//               ld_size_i  [2:0]  load size code + unsigned flag
//               ld_off_i   [1:0]  load byte offset
//               ld_rdata_i [31:0] raw bus word
//               ld_data_o  [31:0] extended load data
// Revision    : 1.0 - initial release
// ============================================================================
module rv32_mod_lsu_lane
   import rv32_pkg::*;
(
   input  logic [1:0]  st_size_i,
   input  logic [1:0]  st_off_i,
   input  logic [31:0] st_wdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic        misalign_o,
   input  logic [2:0]  ld_size_i,
   input  logic [1:0]  ld_off_i,
   input  logic [31:0] ld_rdata_i,
   output logic [31:0] ld_data_o
);

   logic [31:0] w_shifted;
   logic        w_sext;

   always_comb begin
      be_o       = 4'b0000;
      wdata_o    = st_wdata_i;
      misalign_o = 1'b0;
      case (st_size_i)
         MEM_SIZE_B: begin
            be_o    = 4'b0001 << st_off_i;
            wdata_o = {4{st_wdata_i[7:0]}};
         end
         MEM_SIZE_H: begin
            be_o       = 4'b0011 << st_off_i;
            wdata_o    = {2{st_wdata_i[15:0]}};
            misalign_o = st_off_i[0];
         end
         MEM_SIZE_W: begin
            be_o       = 4'b1111;
            misalign_o = |st_off_i;
         end
         default: begin
            misalign_o = 1'b1;
         end
      endcase
   end

   // Move the addressed byte/half down to bit 0 before extending
   assign w_shifted = ld_rdata_i >> {ld_off_i, 3'b000};

   always_comb begin
      ld_data_o = ld_rdata_i;
      w_sext    = 1'b0;
      case (ld_size_i[1:0])
         MEM_SIZE_B: begin
            w_sext    = ~ld_size_i[MEM_UNSIGNED_BIT] & w_shifted[7];
            ld_data_o = {{24{w_sext}}, w_shifted[7:0]};
         end
         MEM_SIZE_H: begin
            w_sext    = ~ld_size_i[MEM_UNSIGNED_BIT] & w_shifted[15];
            ld_data_o = {{16{w_sext}}, w_shifted[15:0]};
         end
         default: begin
            ld_data_o = ld_rdata_i;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/rv32_mod_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rv32_mod_mem_arbiter
// Description : Shares one external memory port between instruction fetch
//               (IF) and load/store (LS). LS has fixed priority. Runs the
//               bus handshake with an optional timeout, builds byte enables,
//               extends load data and reports alignment/bus errors.
// Ports       : clk, rst                  clock, sync active-high reset
//               if_req/if_addr            fetch request (word aligned read)
//               if_rdata/if_ack/if_err    fetch response (1-cycle pulse)
//               ls_req/ls_wr/ls_size/ls_addr/ls_wdata  load/store request
//               ls_rdata/ls_ack/ls_err    load/store response (1-cycle pulse)
//               bus_req/bus_wr/bus_addr/bus_be/bus_wdata  external request
//               bus_rdata/bus_ack/bus_err external completion
// Revision    : 1.0 - initial release
// ============================================================================
module rv32_mod_mem_arbiter
   import rv32_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ack,
   output logic        if_err,
   input  logic        ls_req,
   input  logic        ls_wr,
   input  logic [3:0]  ls_size,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic [31:0] ls_rdata,
   output logic        ls_ack,
   output logic        ls_err,
   output logic        bus_req,
   output logic        bus_wr,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   input  logic        bus_err
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

   arb_state_t       state_q, state_d;
   logic             gnt_ls_q, gnt_ls_d;
   logic [31:2]      addr_q, addr_d;
   logic             wr_q, wr_d;
   logic [3:0]       be_q, be_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [2:0]       ld_size_q, ld_size_d;
   logic [1:0]       ld_off_q, ld_off_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic [31:0]      rdata_q, rdata_d;

   logic [3:0]       w_be;
   logic [31:0]      w_wdata;
   logic             w_misalign;
   logic [31:0]      w_ld_data;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_timeout;
   logic             w_in_bus;
   logic             unused_bits;

   // Store side looks at the live LS request (used only in IDLE);
   // load side uses the size/offset latched at grant time.
   rv32_mod_lsu_lane u_lane (
      .st_size_i  (ls_size[1:0]),
      .st_off_i   (ls_addr[1:0]),
      .st_wdata_i (ls_wdata),
      .be_o       (w_be),
      .wdata_o    (w_wdata),
      .misalign_o (w_misalign),
      .ld_size_i  (ld_size_q),
      .ld_off_i   (ld_off_q),
      .ld_rdata_i (bus_rdata),
      .ld_data_o  (w_ld_data)
   );

   assign w_cnt_inc = cnt_q + 1'b1;
   assign w_timeout = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == TO_LIMIT);

   always_comb begin
      state_d   = state_q;
      gnt_ls_d  = gnt_ls_q;
      addr_d    = addr_q;
      wr_d      = wr_q;
      be_d      = be_q;
      wdata_d   = wdata_q;
      ld_size_d = ld_size_q;
      ld_off_d  = ld_off_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      rdata_d   = rdata_q;
      case (state_q)
         IDLE: begin
            cnt_d   = '0;
            err_d   = 1'b0;
            rdata_d = '0;
            if (ls_req) begin
               gnt_ls_d  = 1'b1;
               addr_d    = ls_addr[31:2];
               wr_d      = ls_wr;
               be_d      = w_be;
               wdata_d   = w_wdata;
               ld_size_d = ls_size[2:0];
               ld_off_d  = ls_addr[1:0];
               if (w_misalign) begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end else begin
                  state_d = BUS;
               end
            end else if (if_req) begin
               gnt_ls_d  = 1'b0;
               addr_d    = if_addr[31:2];
               wr_d      = 1'b0;
               be_d      = 4'b1111;
               wdata_d   = '0;
               ld_size_d = {1'b0, MEM_SIZE_W};
               ld_off_d  = 2'b00;
               state_d   = BUS;
            end
         end
         BUS: begin
            cnt_d = w_cnt_inc;
            if (bus_err) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = RESP;
            end else if (bus_ack) begin
               err_d   = 1'b0;
               // Stores return no data; fetches take the raw word
               rdata_d = gnt_ls_q ? (wr_q ? 32'd0 : w_ld_data) : bus_rdata;
               state_d = RESP;
            end else if (w_timeout) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         gnt_ls_q  <= 1'b0;
         addr_q    <= '0;
         wr_q      <= 1'b0;
         be_q      <= '0;
         wdata_q   <= '0;
         ld_size_q <= '0;
         ld_off_q  <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         gnt_ls_q  <= gnt_ls_d;
         addr_q    <= addr_d;
         wr_q      <= wr_d;
         be_q      <= be_d;
         wdata_q   <= wdata_d;
         ld_size_q <= ld_size_d;
         ld_off_q  <= ld_off_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
      end
   end

   // Bus-side outputs are forced to 0 whenever no transaction is on the bus
   assign w_in_bus  = (state_q == BUS);
   assign bus_req   = w_in_bus;
   assign bus_wr    = w_in_bus & wr_q;
   assign bus_addr  = w_in_bus ? {addr_q, 2'b00} : 32'd0;
   assign bus_be    = w_in_bus ? be_q : 4'b0000;
   assign bus_wdata = w_in_bus ? wdata_q : 32'd0;

   assign if_ack   = (state_q == RESP) & ~gnt_ls_q;
   assign if_err   = if_ack & err_q;
   assign if_rdata = if_ack ? rdata_q : 32'd0;
   assign ls_ack   = (state_q == RESP) & gnt_ls_q;
   assign ls_err   = ls_ack & err_q;
   assign ls_rdata = ls_ack ? rdata_q : 32'd0;

   assign unused_bits = ^{if_addr[1:0], ls_size[3]};

endmodule
`default_nettype wire

// File: tb/tb_rv32_mod_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32_mod_mem_arbiter
// Description : Directed bench for rv32_mod_mem_arbiter (TIMEOUT_CYCLES=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32_mod_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        if_err;
   logic        ls_req;
   logic        ls_wr;
   logic [3:0]  ls_size;
   logic [31:0] ls_addr;
   logic [31:0] ls_wdata;
   logic [31:0] ls_rdata;
   logic        ls_ack;
   logic        ls_err;
   logic        bus_req;
   logic        bus_wr;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack;
   logic        bus_err;

   int total = 0;
   int bad   = 0;

   rv32_mod_mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_ack    (if_ack),
      .if_err    (if_err),
      .ls_req    (ls_req),
      .ls_wr     (ls_wr),
      .ls_size   (ls_size),
      .ls_addr   (ls_addr),
      .ls_wdata  (ls_wdata),
      .ls_rdata  (ls_rdata),
      .ls_ack    (ls_ack),
      .ls_err    (ls_err),
      .bus_req   (bus_req),
      .bus_wr    (bus_wr),
      .bus_addr  (bus_addr),
      .bus_be    (bus_be),
      .bus_wdata (bus_wdata),
      .bus_rdata (bus_rdata),
      .bus_ack   (bus_ack),
      .bus_err   (bus_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; if_req = 0; if_addr = 0; ls_req = 0; ls_wr = 0; ls_size = 0;
      ls_addr = 0; ls_wdata = 0; bus_rdata = 0; bus_ack = 0; bus_err = 0;
      tick(); tick();
      chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
      chk("rst_if_ack",  {31'd0, if_ack},  32'd0);
      chk("rst_ls_ack",  {31'd0, ls_ack},  32'd0);
      chk("rst_bus_addr", bus_addr, 32'd0);
      chk("rst_bus_be",  {28'd0, bus_be},  32'd0);
      rst = 1'b0;
      tick();

      // IF fetch, bus acks on second BUS cycle
      if_req = 1; if_addr = 32'h0000_0100;
      tick();
      chk("if_bus_req",  {31'd0, bus_req}, 32'd1);
      chk("if_bus_addr", bus_addr, 32'h0000_0100);
      chk("if_bus_be",   {28'd0, bus_be},  32'hF);
      chk("if_bus_wr",   {31'd0, bus_wr},  32'd0);
      tick();
      chk("if_no_ack_yet", {31'd0, if_ack}, 32'd0);
      bus_ack = 1; bus_rdata = 32'hDEAD_BEEF;
      tick();
      bus_ack = 0;
      chk("if_ack",    {31'd0, if_ack}, 32'd1);
      chk("if_err",    {31'd0, if_err}, 32'd0);
      chk("if_rdata",  if_rdata, 32'hDEAD_BEEF);
      chk("if_req_drop", {31'd0, bus_req}, 32'd0);
      if_req = 0;
      tick();
      chk("if_ack_pulse", {31'd0, if_ack}, 32'd0);
      chk("if_rdata_zero", if_rdata, 32'd0);

      // Signed byte load at offset 3
      ls_req = 1; ls_wr = 0; ls_size = 4'b0000; ls_addr = 32'h0000_0203;
      tick();
      chk("lb_be",   {28'd0, bus_be}, 32'h8);
      chk("lb_addr", bus_addr, 32'h0000_0200);
      bus_ack = 1; bus_rdata = 32'h8011_2233;
      tick();
      bus_ack = 0;
      chk("lb_ack",   {31'd0, ls_ack}, 32'd1);
      chk("lb_rdata", ls_rdata, 32'hFFFF_FF80);
      chk("lb_if_ack", {31'd0, if_ack}, 32'd0);
      ls_req = 0;
      tick();

      // Unsigned byte load, same address
      ls_req = 1; ls_size = 4'b0100;
      tick();
      bus_ack = 1;
      tick();
      bus_ack = 0;
      chk("lbu_rdata", ls_rdata, 32'h0000_0080);
      ls_req = 0;
      tick();

      // Signed half load at offset 2
      ls_req = 1; ls_size = 4'b0001; ls_addr = 32'h0000_0102;
      tick();
      chk("lh_be", {28'd0, bus_be}, 32'hC);
      bus_ack = 1; bus_rdata = 32'h8001_7F00;
      tick();
      bus_ack = 0;
      chk("lh_rdata", ls_rdata, 32'hFFFF_8001);
      ls_req = 0;
      tick();

      // Half store at offset 2
      ls_req = 1; ls_wr = 1; ls_size = 4'b0001; ls_addr = 32'h0000_0302; ls_wdata = 32'h0000_ABCD;
      tick();
      chk("sh_addr",  bus_addr, 32'h0000_0300);
      chk("sh_be",    {28'd0, bus_be}, 32'hC);
      chk("sh_wdata", bus_wdata, 32'hABCD_ABCD);
      chk("sh_wr",    {31'd0, bus_wr}, 32'd1);
      bus_ack = 1;
      tick();
      bus_ack = 0;
      chk("sh_ack", {31'd0, ls_ack}, 32'd1);
      chk("sh_err", {31'd0, ls_err}, 32'd0);
      ls_req = 0; ls_wr = 0;
      tick();

      // Byte store at offset 1
      ls_req = 1; ls_wr = 1; ls_size = 4'b0000; ls_addr = 32'h0000_0311; ls_wdata = 32'h1234_565A;
      tick();
      chk("sb_be",    {28'd0, bus_be}, 32'h2);
      chk("sb_wdata", bus_wdata, 32'h5A5A_5A5A);
      bus_ack = 1;
      tick();
      bus_ack = 0;
      ls_req = 0; ls_wr = 0;
      tick();

      // Contention: LS wins, IF follows two cycles after ls_ack
      ls_req = 1; ls_size = 4'b0010; ls_addr = 32'h0000_0500;
      if_req = 1; if_addr = 32'h0000_0600;
      tick();
      chk("ct_ls_first", bus_addr, 32'h0000_0500);
      bus_ack = 1; bus_rdata = 32'h1234_5678;
      tick();
      bus_ack = 0;
      chk("ct_ls_ack",   {31'd0, ls_ack}, 32'd1);
      chk("ct_ls_rdata", ls_rdata, 32'h1234_5678);
      chk("ct_if_wait",  {31'd0, if_ack}, 32'd0);
      ls_req = 0;
      tick();
      chk("ct_gap", {31'd0, bus_req}, 32'd0);
      tick();
      chk("ct_if_req",  {31'd0, bus_req}, 32'd1);
      chk("ct_if_addr", bus_addr, 32'h0000_0600);
      bus_ack = 1; bus_rdata = 32'h0BAD_F00D;
      tick();
      bus_ack = 0;
      chk("ct_if_rdata", if_rdata, 32'h0BAD_F00D);
      if_req = 0;
      tick();

      // Misaligned word load: immediate error, no bus cycle
      ls_req = 1; ls_size = 4'b0010; ls_addr = 32'h0000_0401;
      tick();
      chk("mis_ack",     {31'd0, ls_ack},  32'd1);
      chk("mis_err",     {31'd0, ls_err},  32'd1);
      chk("mis_bus_req", {31'd0, bus_req}, 32'd0);
      chk("mis_rdata",   ls_rdata, 32'd0);
      ls_req = 0;
      tick();

      // Invalid size code
      ls_req = 1; ls_size = 4'b0011; ls_addr = 32'h0000_0400;
      tick();
      chk("inv_err", {31'd0, ls_err}, 32'd1);
      ls_req = 0;
      tick();

      // Timeout after 4 BUS cycles
      if_req = 1; if_addr = 32'h0000_0700;
      tick();
      chk("to_req_0", {31'd0, bus_req}, 32'd1);
      for (int i = 1; i < 4; i++) begin
         tick();
         chk("to_req_held", {31'd0, bus_req}, 32'd1);
      end
      tick();
      chk("to_req_drop", {31'd0, bus_req}, 32'd0);
      chk("to_ack",      {31'd0, if_ack},  32'd1);
      chk("to_err",      {31'd0, if_err},  32'd1);
      chk("to_rdata",    if_rdata, 32'd0);
      if_req = 0;
      tick();

      // bus_ack and bus_err together: error wins
      ls_req = 1; ls_size = 4'b0010; ls_addr = 32'h0000_0800;
      tick();
      bus_ack = 1; bus_err = 1; bus_rdata = 32'h0000_FFFF;
      tick();
      bus_ack = 0; bus_err = 0;
      chk("ae_ack",   {31'd0, ls_ack}, 32'd1);
      chk("ae_err",   {31'd0, ls_err}, 32'd1);
      chk("ae_rdata", ls_rdata, 32'd0);
      ls_req = 0;
      tick();

      // Reset during BUS, then the re-issued fetch completes
      if_req = 1; if_addr = 32'h0000_0900;
      tick();
      chk("rb_bus_req", {31'd0, bus_req}, 32'd1);
      rst = 1;
      tick();
      rst = 0;
      chk("rb_dropped", {31'd0, bus_req}, 32'd0);
      chk("rb_no_ack",  {31'd0, if_ack},  32'd0);
      tick();
      chk("rb_reissue", bus_addr, 32'h0000_0900);
      bus_ack = 1; bus_rdata = 32'hCAFE_F00D;
      tick();
      bus_ack = 0;
      chk("rb_ack",   {31'd0, if_ack}, 32'd1);
      chk("rb_rdata", if_rdata, 32'hCAFE_F00D);
      if_req = 0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
